// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encoding and the default operand width.
package serial_adder_pkg;

  // Operand/result width used when the instantiating code does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states: waiting for a request, or stepping through the bits.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder. This is the only arithmetic element in the serial
// adder; all WIDTH bits are pushed through it one per clock.
module full_adder_cell (
  input  logic x1,
  input  logic x2,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum is the parity of the three inputs; carry is their majority.
  always_comb begin
    s    = x1 ^ x2 ^ cin;
    cout = (x1 & x2) | (x1 & cin) | (x2 & cin);
  end

endmodule

// File: rtl/serial_adder_nbit.sv
// Bit-serial adder/subtractor. Operands are captured on an accepted start,
// then one bit per clock (LSB first) goes through a single full-adder cell.
// After WIDTH run cycles the result, carry-out and signed overflow are
// latched together and a one-cycle done pulse is raised.
module serial_adder_nbit
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  // Counter wide enough to hold 0..WIDTH; derived from WIDTH only.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Controller state.
  state_t state_reg;
  state_t state_next;

  // Control strobes decoded from the state.
  logic load;   // capture operands this edge
  logic step;   // process one bit this edge
  logic last;   // this edge processes the MSB

  // Datapath registers.
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Output registers.
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             overflow_reg;
  logic             done_reg;

  // Full-adder results for the bit currently at the bottom of the shifters.
  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] res_next;

  full_adder_cell u_fa (
    .x1   (a_sh_reg[0]),
    .x2   (b_sh_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts the LSB of
  // the result has arrived at bit 0.
  assign res_next = {fa_s, res_sh_reg[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and control decode. start is only looked at in IDLE, which
  // includes the cycle in which done is high, so back-to-back requests are
  // accepted without a dead cycle.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt_reg == LAST_CNT) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand shifters, running carry and bit counter. Subtraction is done
  // as a + ~b + 1, so b is inverted at capture and the carry preset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else if (load) begin
      a_sh_reg   <= a;
      b_sh_reg   <= b ^ {WIDTH{sub}};
      res_sh_reg <= '0;
      carry_reg  <= sub ? 1'b1 : cin;
      cnt_reg    <= '0;
    end else if (step) begin
      a_sh_reg   <= a_sh_reg >> 1;
      b_sh_reg   <= b_sh_reg >> 1;
      res_sh_reg <= res_next;
      carry_reg  <= fa_cout;
      cnt_reg    <= cnt_reg + CNT_W'(1);
    end
  end

  // Result latch and done pulse. On the MSB step carry_reg still holds the
  // carry into the MSB, so overflow is that value XOR the final carry out.
  // Outputs only move on this edge, so they hold between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg      <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= last;
      if (last) begin
        sum_reg      <= res_next;
        cout_reg     <= fa_cout;
        overflow_reg <= carry_reg ^ fa_cout;
      end
    end
  end

  assign done     = done_reg;
  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed bench for the serial adder: an 8-bit instance for the directed
// scenarios and a 4-bit instance swept over every operand combination.
module tb_serial_adder_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 8-bit instance
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8, sum8;
  logic       busy8, done8, cout8, ov8;

  // 4-bit instance
  logic       start4, sub4, cin4;
  logic [3:0] a4, b4, sum4;
  logic       busy4, done4, cout4, ov4;

  int n_assert = 0;
  int n_fail   = 0;

  serial_adder_nbit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .overflow(ov8)
  );

  serial_adder_nbit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .overflow(ov4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts falling edges until done8 is seen (bounded).
  task automatic wait_done8(output int n);
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One 8-bit operation; operands are scrambled right after capture.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic c, input string tag);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; sub8 = ~s; cin8 = ~c;
    check({tag, " busy"}, busy8, 1);
    wait_done8(n);
    check({tag, " latency"}, n, 8);
    check({tag, " busy_at_done"}, busy8, 0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [4:0] full;
    logic [3:0] ea, eb;
    logic       eov;

    rst = 1'b1;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
    start4 = 0; sub4 = 0; cin4 = 0; a4 = 0; b4 = 0;
    #2;
    check("rst busy", busy8, 0);
    check("rst done", done8, 0);
    check("rst sum", sum8, 0);
    check("rst cout", cout8, 0);
    check("rst ov", ov8, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: 0F + 01 + 0
    op8(8'h0F, 8'h01, 1'b0, 1'b0, "t1");
    check("t1 sum", sum8, 8'h10);
    check("t1 cout", cout8, 0);
    check("t1 ov", ov8, 0);
    $display("t1 add 0F+01+0 -> sum=%h cout=%b ov=%b", sum8, cout8, ov8);

    // 2: FF + 01 + 1
    op8(8'hFF, 8'h01, 1'b0, 1'b1, "t2");
    check("t2 sum", sum8, 8'h01);
    check("t2 cout", cout8, 1);
    check("t2 ov", ov8, 0);
    $display("t2 add FF+01+1 -> sum=%h cout=%b ov=%b", sum8, cout8, ov8);

    // 3: 7F + 01
    op8(8'h7F, 8'h01, 1'b0, 1'b0, "t3");
    check("t3 sum", sum8, 8'h80);
    check("t3 cout", cout8, 0);
    check("t3 ov", ov8, 1);
    $display("t3 add 7F+01 -> sum=%h cout=%b ov=%b", sum8, cout8, ov8);

    // 4: 05 - 07, cin must be ignored
    op8(8'h05, 8'h07, 1'b1, 1'b0, "t4");
    check("t4 sum", sum8, 8'hFE);
    check("t4 cout", cout8, 0);
    check("t4 ov", ov8, 0);
    $display("t4 sub 05-07 -> sum=%h cout=%b ov=%b", sum8, cout8, ov8);

    // 5a: start re-pulsed while busy must not disturb 0F+01
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; sub8 = 0; cin8 = 0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
    end
    check("t5a latency", n, 8);
    check("t5a sum", sum8, 8'h10);
    $display("t5a restart ignored -> sum=%h after %0d cycles", sum8, n);

    // 5b: reset at cycle 4 of a run aborts it asynchronously
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; sub8 = 0; cin8 = 0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("t5b busy_before_rst", busy8, 1);
    rst = 1'b1;
    #1;
    check("t5b rst busy", busy8, 0);
    check("t5b rst done", done8, 0);
    check("t5b rst sum", sum8, 0);
    check("t5b rst cout", cout8, 0);
    check("t5b rst ov", ov8, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) pulses++;
    end
    check("t5b no_done", pulses, 0);
    check("t5b sum_held", sum8, 0);
    $display("t5b mid-run reset -> busy=%b sum=%h done_pulses=%0d", busy8, sum8, pulses);

    // 6: back-to-back with start held through done
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; sub8 = 0; cin8 = 0; start8 = 1'b1;
    @(negedge clk);
    wait_done8(n);
    check("t6 first latency", n, 8);
    check("t6 first sum", sum8, 8'h03);
    a8 = 8'h80; b8 = 8'h80;
    @(negedge clk);
    start8 = 1'b0;
    check("t6 accepted_on_done", busy8, 1);
    n = 1;
    while (done8 !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("t6 done_spacing", n, 9);
    check("t6 second sum", sum8, 8'h00);
    check("t6 second cout", cout8, 1);
    check("t6 second ov", ov8, 1);
    $display("t6 back-to-back -> spacing=%0d sum=%h cout=%b ov=%b", n, sum8, cout8, ov8);

    // Exhaustive WIDTH=4: add cin=0, add cin=1, subtract
    for (int m = 0; m < 3; m++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          ea = 4'(ia);
          eb = 4'(ib);
          @(negedge clk);
          a4 = ea; b4 = eb; sub4 = (m == 2); cin4 = (m == 1); start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          n = 0;
          while (done4 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
          end
          if (m == 2) begin
            full = {1'b0, ea} + {1'b0, ~eb} + 5'd1;
            eov  = (ea[3] != eb[3]) && (full[3] != ea[3]);
          end else begin
            full = {1'b0, ea} + {1'b0, eb} + 5'(m);
            eov  = (ea[3] == eb[3]) && (full[3] != ea[3]);
          end
          check($sformatf("w4 m%0d %h,%h latency", m, ea, eb), n, 4);
          check($sformatf("w4 m%0d %h,%h sum", m, ea, eb), sum4, full[3:0]);
          check($sformatf("w4 m%0d %h,%h cout", m, ea, eb), cout4, full[4]);
          check($sformatf("w4 m%0d %h,%h ov", m, ea, eb), ov4, eov);
        end
      end
      $display("w4 sweep mode %0d complete, failures so far %0d", m, n_fail);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
